ring_grant_scheduler: RTL
=========================

# ring_grant_scheduler

Round-robin scheduler that shares one resource among N requesters using a one-hot rotating ring pointer. The pointer advances like a ring counter each time a grant is released. Each grant is held while the owner keeps requesting, up to a hold limit. The block sits between the requesting sub-blocks and the shared datapath and drives its one-hot select.

## Interface
- N, default 4: number of requesters (≥2).
- MAX_HOLD, default 8: maximum consecutive cycles one grant may be held (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset. rst=0 resets immediately, independent of clk.
- en  input  1  permits new grants when high. Does not pre-empt a grant already issued.
- req  input  N  request vector, one bit per requester, level-sensitive.
- gnt  output  N  registered one-hot grant, or all zeros.
- gnt_id  output  clog2(N)  registered binary index of the granted requester. Holds its last value when gnt=0.
- busy  output  1  registered; high while in state GRANT.
- timeout  output  1  registered one-cycle pulse, high when a grant ended because of MAX_HOLD.
- ptr  output  N  one-hot ring pointer marking the highest-priority requester.

## Operation
- **Reset values:** state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, hold_cnt=0, ptr=1 (bit 0 set).
- **hold_cnt** is clog2(MAX_HOLD+1) bits wide. It never exceeds MAX_HOLD and never wraps.

State IDLE:
- At a clock edge with en=1 and req≠0, the winner is the first set req bit found by searching from the ptr bit upward, circularly: ptr bit, ptr+1, …, wrapping from N-1 to 0.
- On a win: gnt=onehot(winner), gnt_id=winner, busy=1, hold_cnt=1, go to GRANT.
- Otherwise remain in IDLE with gnt=0.

State GRANT (owner = gnt_id):
- **Release** happens at an edge where req[owner]=0 or hold_cnt==MAX_HOLD. On release:
  - gnt=0, busy=0, go to IDLE.
  - ptr rotates left by one: the owner's one-hot shifted up one bit, with bit N-1 wrapping to bit 0.
  - timeout=1 only if req[owner]=1 at that edge, i.e. release was caused by the limit alone.
- Otherwise hold_cnt increments by 1, and gnt/gnt_id are held.
- Requests from other requesters never pre-empt the owner.
- en=0 has no effect in GRANT.

General rules:
- timeout is 0 in every cycle except the single cycle after a limit release.
- ptr changes only on release, and is always exactly one-hot.
- gnt is never multi-hot.
- **Reset mid-grant:** all outputs return to reset values asynchronously. After rst rises, the first grant needs a clock edge in IDLE.

## Timing
- **Grant latency:** req and en sampled high at edge t, so gnt is asserted after edge t, one cycle after req is visible.
- **Release latency:** req[owner] sampled low at edge k, so gnt drops after edge k.
- **Maximum grant length:** exactly MAX_HOLD cycles of gnt high.
- **Mandatory gap:** at least one cycle with gnt=0 between consecutive grants, even if other requests are pending.
- **Continuous full load:** the grant period is MAX_HOLD+1 cycles per requester, and all N requesters are served within N·(MAX_HOLD+1) cycles, so there is no starvation.
- **Simultaneous owner drop and limit reached:** treated as a normal release, with timeout=0.
- **Owner re-asserts req in the gap cycle:** it competes normally. It has the lowest priority, since ptr has already rotated past it.

## Test plan
1. **Reset mid-grant.** Grant bit 2, then pulse rst=0 between edges. Required: gnt=0000, busy=0, ptr=0001 immediately. After rst=1 with req=0100, gnt=0100 one edge later.
2. **Single requester.** req=0001 for 3 cycles, then 0. Required: gnt=0001 from the edge after req rises, dropping at the edge that samples req=0. ptr=0010 afterwards, timeout stays 0.
3. **Full load.** req=1111, en=1, MAX_HOLD=8. Required: gnt sequence 0001, 0010, 0100, 1000, 0001, each high for exactly 8 cycles with a 1-cycle zero gap. timeout pulses once per release. gnt_id sequence 0, 1, 2, 3, 0.
4. **Priority search.** Force ptr=0100 by granting and releasing bit 1, then apply req=1011. Required: gnt=1000, gnt_id=3.
5. **Enable gating.** en=0 with req=1111 gives gnt=0000 indefinitely. Dropping en during a grant of 0010 lets that grant run to release, and no new grant is issued until en=1.
6. **Handover with limit tie.** Owner 0 drops req on the same edge that hold_cnt reaches 8, while req[1]=1. Required: timeout=0, one gap cycle, then gnt=0010.

Source files
------------

// File: rtl/ring_grant_scheduler.sv
// ring_grant_scheduler
// Shares one resource among N requesters. A one-hot ring pointer marks the
// highest-priority requester; the winner is the first requester found by
// searching circularly upward from the pointer. A grant is held while the
// owner keeps requesting, for at most MAX_HOLD cycles. Every release rotates
// the pointer to the bit just above the owner and forces one idle cycle.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   en       permits new grants (never pre-empts a live grant)
//   req      level-sensitive request vector, one bit per requester
//   gnt      registered one-hot grant, or all zeros
//   gnt_id   registered binary index of the owner (holds when gnt=0)
//   busy     registered, high while a grant is live
//   timeout  registered one-cycle pulse after a release forced by MAX_HOLD
//   ptr      one-hot ring pointer (highest-priority requester)
module ring_grant_scheduler #(
  parameter int  N        = 4,
  parameter int  MAX_HOLD = 8,
  localparam int IDW      = $clog2(N),
  localparam int HCW      = $clog2(MAX_HOLD + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout,
  output logic [N-1:0]   ptr
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state;
  logic [HCW-1:0]   hold_cnt;

  // Circular search: rotate a doubled request vector down by the pointer
  // index so the lowest set bit of the window is the winner's offset.
  int               base;
  logic [2*N-1:0]   rot2;
  logic             found;
  logic [IDW-1:0]   win_id;
  logic             owner_req;

  always_comb begin
    base = 0;
    for (int i = 0; i < N; i++)
      if (ptr[i]) base = i;
    rot2   = {req, req} >> base;
    found  = 1'b0;
    win_id = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot2[k]) begin
        found  = 1'b1;
        win_id = IDW'((base + k) % N);
      end
    end
  end

  // gnt is one-hot while granted, so this picks out req[owner].
  assign owner_req = |(req & gnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      ptr      <= {{(N-1){1'b0}}, 1'b1};
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (en && found) begin
            gnt      <= {{(N-1){1'b0}}, 1'b1} << win_id;
            gnt_id   <= win_id;
            busy     <= 1'b1;
            hold_cnt <= HCW'(1);
            state    <= GRANT;
          end else begin
            gnt <= '0;
          end
        end
        GRANT: begin
          if (!owner_req || hold_cnt == HCW'(MAX_HOLD)) begin
            gnt      <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            state    <= IDLE;
            // Pointer moves to the bit just above the owner.
            ptr      <= {gnt[N-2:0], gnt[N-1]};
            // Only a limit release with the owner still asking is a timeout.
            timeout  <= owner_req;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
